// File: rtl/tlb_lookup_stage.sv
// tlb_lookup_stage
//
// Pipeline stage in front of the data-cache stage. It registers the ALU-stage
// result and the memory-op control, translates the address (identity mapping
// for now) and looks the address up in a mirror of the data cache's
// tag/valid/dirty state. On a miss it stalls the pipeline and runs an optional
// write-back of the victim line followed by a fill from main memory. The
// petitionFromTlb / lineIdFromTlb / writeEnableFromTlb strobes tell the cache
// stage when to drive a line out to memory or to capture a line from memory.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   enable_tlb                 pipeline-register enable from the hazard unit
//   alu_result                 virtual address (memory ops) or ALU result
//   destReg_addr_input, we_input, bp_input, dataReg_input,
//   ldSt_enable_input (bit1 load, bit0 store), word_access_input
//                              fields captured by the pipeline register
//   tlb_result ... word_access_from_tlb
//                              registered fields to the cache stage
//   petitionFromTlb, lineIdFromTlb, writeEnableFromTlb
//                              line transfer strobes to the data cache
//   mem_req, mem_we, mem_addr  line request to main memory (held until ready)
//   mem_ready                  one-cycle completion pulse from memory
//   stall_pipeline             freezes upstream stages during a miss

module tlb_lookup_stage #(
  parameter int addr_width      = 16,
  parameter int num_cache_lines = 4,
  parameter int offset_bits     = 5,
  localparam int tag_width      = addr_width - offset_bits,
  localparam int line_width     = $clog2(num_cache_lines)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_tlb,
  input  logic [addr_width-1:0] alu_result,
  input  logic [2:0]            destReg_addr_input,
  input  logic                  we_input,
  input  logic [1:0]            bp_input,
  input  logic [15:0]           dataReg_input,
  input  logic [1:0]            ldSt_enable_input,
  input  logic                  word_access_input,
  output logic [addr_width-1:0] tlb_result,
  output logic [2:0]            destReg_addr_output,
  output logic                  we_output,
  output logic [1:0]            bp_output,
  output logic [15:0]           dataReg_output,
  output logic [1:0]            ldSt_enable_output,
  output logic                  word_access_from_tlb,
  output logic                  petitionFromTlb,
  output logic [line_width-1:0] lineIdFromTlb,
  output logic                  writeEnableFromTlb,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr,
  input  logic                  mem_ready,
  output logic                  stall_pipeline
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_FILL
  } state_t;

  state_t state_reg, state_next;

  // Pipeline register
  logic [addr_width-1:0] addr_reg;
  logic [2:0]            dest_reg;
  logic                  we_reg;
  logic [1:0]            bp_reg;
  logic [15:0]           data_reg;
  logic [1:0]            ldst_reg;
  logic                  word_reg;

  // Mirror of the data cache's line state
  logic [tag_width-1:0]       tag_reg [num_cache_lines];
  logic [num_cache_lines-1:0] valid_reg;
  logic [num_cache_lines-1:0] dirty_reg;
  logic [line_width-1:0]      victim_reg;
  logic [line_width-1:0]      victim_next;

  logic [tag_width-1:0]       addr_tag;
  logic [num_cache_lines-1:0] hit_vec;
  logic                       hit_any;
  logic [line_width-1:0]      hit_line;
  logic                       mem_op;
  logic                       miss;
  logic                       load_en;
  logic                       store_hit_commit;

  assign addr_tag = addr_reg[addr_width-1:offset_bits];
  assign mem_op   = |ldst_reg;

  genvar gi;
  generate
    for (gi = 0; gi < num_cache_lines; gi++) begin : g_hit
      assign hit_vec[gi] = valid_reg[gi] && (tag_reg[gi] == addr_tag);
    end
  endgenerate

  assign hit_any = |hit_vec;
  assign miss    = mem_op & ~hit_any;

  // At most one line can hold a given tag, so a priority encoder is enough.
  always_comb begin
    hit_line = '0;
    for (int i = num_cache_lines - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_line = line_width'(i);
    end
  end

  assign stall_pipeline = (state_reg != ST_IDLE) | miss;
  assign load_en        = enable_tlb & ~stall_pipeline;

  // A store that hits only marks its line dirty once it actually advances to
  // the cache stage; a held store must not dirty the line twice or early.
  assign store_hit_commit = (state_reg == ST_IDLE) & ldst_reg[0] & hit_any & load_en;

  assign victim_next = (victim_reg == line_width'(num_cache_lines - 1)) ?
                       '0 : victim_reg + 1'b1;

  // Next-state and memory / cache strobes
  always_comb begin
    state_next         = state_reg;
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    mem_addr           = '0;
    petitionFromTlb    = 1'b0;
    writeEnableFromTlb = 1'b0;
    lineIdFromTlb      = '0;
    case (state_reg)
      ST_IDLE: begin
        if (miss) begin
          if (valid_reg[victim_reg] & dirty_reg[victim_reg]) state_next = ST_WRITEBACK;
          else                                               state_next = ST_FILL;
        end
      end
      ST_WRITEBACK: begin
        // The cache drives the victim line for the whole request so memory
        // sees stable data regardless of its latency.
        mem_req         = 1'b1;
        mem_we          = 1'b1;
        mem_addr        = {tag_reg[victim_reg], {offset_bits{1'b0}}};
        petitionFromTlb = 1'b1;
        lineIdFromTlb   = victim_reg;
        if (mem_ready) state_next = ST_FILL;
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_tag, {offset_bits{1'b0}}};
        if (mem_ready) begin
          // Fill data is only valid while mem_ready is high.
          petitionFromTlb    = 1'b1;
          writeEnableFromTlb = 1'b1;
          lineIdFromTlb      = victim_reg;
          state_next         = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state and mirror updates
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      valid_reg  <= '0;
      dirty_reg  <= '0;
      victim_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (store_hit_commit) dirty_reg[hit_line] <= 1'b1;
        end
        ST_WRITEBACK: begin
          if (mem_ready) dirty_reg[victim_reg] <= 1'b0;
        end
        ST_FILL: begin
          if (mem_ready) begin
            tag_reg[victim_reg]   <= addr_tag;
            valid_reg[victim_reg] <= 1'b1;
            dirty_reg[victim_reg] <= 1'b0;
            victim_reg            <= victim_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg <= '0;
      dest_reg <= '0;
      we_reg   <= 1'b0;
      bp_reg   <= '0;
      data_reg <= '0;
      ldst_reg <= '0;
      word_reg <= 1'b0;
    end else if (load_en) begin
      addr_reg <= alu_result;
      dest_reg <= destReg_addr_input;
      we_reg   <= we_input;
      bp_reg   <= bp_input;
      data_reg <= dataReg_input;
      ldst_reg <= ldSt_enable_input;
      word_reg <= word_access_input;
    end
  end

  // Identity translation. While stalled the cache stage sees a bubble: no
  // memory access and no register write-back.
  assign tlb_result           = addr_reg;
  assign destReg_addr_output  = dest_reg;
  assign bp_output            = bp_reg;
  assign dataReg_output       = data_reg;
  assign word_access_from_tlb = word_reg;
  assign we_output            = stall_pipeline ? 1'b0 : we_reg;
  assign ldSt_enable_output   = stall_pipeline ? 2'b00 : ldst_reg;

endmodule

// File: doc/tlb_lookup_stage.md
# tlb_lookup_stage

Pipeline stage directly upstream of the data-cache stage. It registers the ALU-stage result and memory-op control, performs address translation (identity in this revision), and checks a mirrored tag/valid/dirty array for the 4-line data cache. On a miss it stalls the pipeline and runs a write-back/fill sequence with main memory. It drives the cache stage's `petitionFromTlb` / `lineIdFromTlb` / `writeEnableFromTlb` strobes so line data moves between memory and the cache.

## Interface
Parameters:
- addr_width, 16, virtual/physical address width
- num_cache_lines, 4, data-cache lines (lineId width = 2)
- offset_bits, 5, byte offset within a 32-byte line (tag = addr[15:5], 11 bits)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- enable_tlb  in  1  pipeline-register enable from the hazard controller
- alu_result  in  16  virtual address for memory ops, or ALU result otherwise
- destReg_addr_input, we_input, bp_input  in  3/1/2  forwarded writeback control
- dataReg_input  in  16  store data
- ldSt_enable_input  in  2  bit1 = load, bit0 = store
- word_access_input  in  1  1 = word, 0 = byte
- tlb_result, destReg_addr_output, we_output, bp_output, dataReg_output, ldSt_enable_output, word_access_from_tlb  out  16/3/1/2/16/2/1  registered fields to the cache stage
- petitionFromTlb  out  1  cache-line transfer strobe to the data cache
- lineIdFromTlb  out  2  line being filled or evicted
- writeEnableFromTlb  out  1  1 = fill the line from `dataReadFromMem`; 0 = read the line out on `dataWrittenToMem`
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = line write-back, 0 = line read
- mem_addr  out  16  line-aligned address ({tag, 5'b0})
- mem_ready  in  1  one-cycle completion pulse; ignored while mem_req = 0
- stall_pipeline  out  1  freezes upstream stages

## Operation
- **Pipeline register:** loads all inputs when `enable_tlb & ~stall_pipeline`. It holds otherwise.
- **Translation:** `tlb_result` = registered address, unchanged.
- **Memory op:** the registered op is a memory op when ldSt bit1 or bit0 is set.
  - Hit: `valid[i] && tag[i] == addr[15:5]` for some i.
  - Miss: the op is a memory op and no line hits.
  - Non-memory ops never miss.
- **Mirror state:** per line `tag[10:0]`, `valid`, `dirty`, plus a 2-bit round-robin `victim` pointer.
- **FSM states:** IDLE, WRITEBACK, FILL.
  - IDLE:
    - On a miss, go to WRITEBACK if `valid[victim] & dirty[victim]`; otherwise go to FILL.
    - On a store hit leaving the stage (`enable_tlb & ~stall_pipeline`), set `dirty[hit_line]`.
  - WRITEBACK:
    - Drive `mem_req=1`, `mem_we=1`, `mem_addr={tag[victim],5'b0}`.
    - Drive `petitionFromTlb=1`, `writeEnableFromTlb=0`, `lineIdFromTlb=victim` for the whole state, so memory sees stable line data.
    - On mem_ready, clear `dirty[victim]` and go to FILL.
  - FILL:
    - Drive `mem_req=1`, `mem_we=0`, `mem_addr={addr[15:5],5'b0}`.
    - On mem_ready, in the same cycle:
      - pulse `petitionFromTlb=1`, `writeEnableFromTlb=1`, `lineIdFromTlb=victim`;
      - set `tag[victim]=addr[15:5]`, `valid[victim]=1`, `dirty[victim]=0`;
      - increment `victim` (wraps 3→0);
      - go to IDLE.
- **Stall:** `stall_pipeline = (state != IDLE) | (state == IDLE & miss)`, combinational.
- **Bubble:** while stalled, `ldSt_enable_output=0` and `we_output=0`, so the cache stage captures a bubble. Other fields pass through.
- **Strobe defaults:** outside the cases above, `petitionFromTlb`, `writeEnableFromTlb` and `mem_req` are 0, and `lineIdFromTlb` is 0.
- **Reset, including mid-miss:**
  - State returns to IDLE; all valid/dirty bits, the victim pointer and the pipeline register clear to 0.
  - All outputs are 0 in the cycle after reset.
  - An outstanding request is abandoned; mem_req drops.

## Timing
- Hit or non-memory op: 0 added cycles. Fields are visible one cycle after capture.
- Clean miss detected in cycle T:
  - FILL starts at T+1 with mem_req high.
  - mem_ready arrives at T+1+L; the fill happens in that cycle.
  - IDLE at T+2+L; the op now hits and the stall drops that cycle.
- Dirty miss: adds the WRITEBACK duration (1 + write latency) before FILL.
- mem_req and mem_addr stay stable from the first request cycle until the cycle of mem_ready inclusive.
- mem_ready arriving in the first request cycle is legal (L = 0).

## Test plan
- After reset, load 0x0104 → miss:
  - FILL with `mem_addr=0x0100`;
  - mem_ready after 3 cycles → fill pulse with lineId 0, `writeEnableFromTlb=1`;
  - stall low the next cycle; `tlb_result=0x0104`, `ldSt_enable_output=2'b10`.
- Store to 0x0106 right after → hit, no stall, dirty[0] set. A non-memory op with `alu_result=0xFFFF` → no stall, passed through.
- Fill lines 1–3 (0x0200, 0x0300, 0x0400), then load 0x0500 → victim 0 dirty:
  - WRITEBACK with `mem_addr=0x0100`, `mem_we=1`, petition high with write-enable 0;
  - then FILL 0x0500 into line 0;
  - victim pointer ends at 1.
- mem_ready pulsed while mem_req=0 → no state change.
- mem_ready arriving in the same cycle FILL begins → fill completes with 0 wait cycles.
- Reset asserted mid-FILL → next cycle mem_req=0, stall=0, all lines invalid; re-accessing 0x0104 misses again.
